ripple_count_monitor: RTL and testbench
=======================================

Name: ripple_count_monitor

Overview:
- Consumer stage placed directly downstream of the 4-bit ripple-carry counter, whose D flip-flops advance on negedge clk and clear on reset.
- Samples the settled counter value on the following posedge clk. Checks that the count advances by exactly +1 per cycle.
- Detects wrap-around and a programmable match value. Reports each as an event through a single-entry valid/ready output register.

Parameters:
- WIDTH, 4, counter width in bits; must equal the ripple counter width.
- WRAP_EVT, 1, 1 = a wrap produces an event; 0 = wrap only pulses the wrap output.

Ports:
- clk  in  1  system clock; ripple counter updates on negedge, this block updates on posedge.
- reset  in  1  asynchronous, active-high.
- cnt_in  in  WIDTH  ripple counter output q[WIDTH-1:0].
- arm  in  1  single-cycle pulse; arms the match detector.
- match_val  in  WIDTH  compare value, sampled every cycle.
- cnt_q  out  WIDTH  registered counter sample.
- wrap  out  1  one-cycle pulse when the sample wraps from max to 0.
- armed  out  1  high while the FSM is in ARMED.
- evt_valid  out  1  event register holds an event.
- evt_ready  in  1  consumer accepts the event.
- evt_code  out  2  01 = match, 10 = wrap, 11 = sequence error; 00 when empty.
- evt_count  out  WIDTH  sample value that caused the event.
- overflow  out  1  sticky; an event was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (async, active-high) takes effect immediately, including mid-operation:
  - cnt_q=0, wrap=0, armed=0, evt_valid=0, evt_code=00, evt_count=0, overflow=0.
  - FSM goes to IDLE; the first-sample flag is cleared.
- Sampling:
  - cnt_q <= cnt_in on every posedge; latency is 1 posedge.
  - cnt_in is stable at posedge because it settles within the half cycle after negedge.
- First-sample flag:
  - Set on the first posedge after reset deasserts.
  - The sequence check is suppressed on that first posedge only.
- Sequence check: when the flag is set and cnt_in != (cnt_q + 1) mod 2^WIDTH, raise a sequence-error event (code 11).
- Wrap:
  - When cnt_q == 2^WIDTH-1 and cnt_in == 0, wrap=1 in the cycle where cnt_q shows 0.
  - When WRAP_EVT=1, this also raises a wrap event (code 10).
- FSM (2-bit), states IDLE, ARMED, MATCHED:
  - IDLE: arm=1 -> ARMED.
  - ARMED: cnt_in == match_val at posedge -> raise a match event (code 01) and go to MATCHED.
  - MATCHED: stay until the match event is accepted (evt_valid & evt_ready with code 01) or dropped, then -> IDLE.
  - arm in ARMED or MATCHED is ignored.
  - A match raised in the same posedge that arm enters ARMED does not count; comparison starts on the next posedge.
- Event priority within one cycle: 11 > 01 > 10. Lower-priority simultaneous events are discarded silently (no overflow).
- Event register:
  - Loads when empty, or when evt_valid & evt_ready in the same cycle (back-to-back, no bubble).
  - evt_count = cnt_in value sampled in the event's cycle.
  - A raised event while evt_valid & !evt_ready is dropped, and overflow is set.
  - A dropped match also returns the FSM to IDLE.
- Handshake:
  - Transfer occurs on posedge with evt_valid & evt_ready.
  - After a transfer with no new event, evt_valid=0 and evt_code=00 the next cycle.
  - evt_code and evt_count stay stable while evt_valid & !evt_ready.
- overflow: clr_ovf clears it. If a set and a clear happen in the same cycle, set wins.
- Arithmetic: +1 compare is modulo 2^WIDTH; no carry beyond WIDTH.

Test Plan:
- Free-running counter 0..15 with evt_ready=1 and WRAP_EVT=1:
  - cnt_q trails cnt_in by one posedge.
  - wrap pulses once per 16 cycles, when cnt_q=0.
  - One event per wrap: code 10, count 0. No sequence errors.
- arm pulse with match_val=9, counter at 3:
  - armed=1 until the sample equals 9.
  - evt_code=01, evt_count=9, then armed=0 and FSM in IDLE after acceptance.
- Force cnt_in to jump from 5 to 8: evt_code=11, evt_count=8.
  - With match_val=8 also armed, only code 11 is reported, and overflow stays 0.
- Hold evt_ready=0 across two wraps: first event is held stable, the second is dropped, and overflow=1.
  - clr_ovf with no simultaneous drop clears overflow.
  - clr_ovf in the same cycle as a drop keeps overflow=1.
- Back-to-back: evt_ready=1 while a new event is raised in the same cycle as a transfer; evt_valid stays high and the new code loads with no gap.
- Assert reset asynchronously mid-ARMED with evt_valid=1:
  - All outputs go to 0 immediately.
  - The first post-reset sample (counter 0 then 1) produces no sequence error.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// Posedge consumer for a negedge-clocked ripple counter: samples the count, checks +1 stepping,
// flags wrap and a programmable match, and hands events out through a one-deep valid/ready register.
module ripple_count_monitor #(
  parameter int WIDTH    = 4,
  parameter bit WRAP_EVT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             arm,
  input  logic [WIDTH-1:0] match_val,
  output logic [WIDTH-1:0] cnt_q,
  output logic             wrap,
  output logic             armed,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_count,
  output logic             overflow,
  input  logic             clr_ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MATCHED = 2'd2
  } state_t;

  localparam logic [1:0]       CODE_NONE  = 2'b00;
  localparam logic [1:0]       CODE_MATCH = 2'b01;
  localparam logic [1:0]       CODE_WRAP  = 2'b10;
  localparam logic [1:0]       CODE_SEQ   = 2'b11;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;

  // Expected next count; the carry out of the top bit is deliberately discarded.
  function automatic logic [WIDTH-1:0] inc_mod(input logic [WIDTH-1:0] v);
    return v + CNT_ONE;
  endfunction

  state_t     state;
  logic       first_p0;
  logic       seq_err;
  logic       wrap_hit;
  logic       wrap_raise;
  logic       match_hit;
  logic       raise;
  logic       xfer;
  logic       load;
  logic       drop;
  logic [1:0] code_new;

  always_comb begin
    seq_err    = first_p0 && (cnt_in != inc_mod(cnt_q));
    wrap_hit   = (cnt_q == CNT_MAX) && (cnt_in == '0);
    wrap_raise = WRAP_EVT && wrap_hit;
    match_hit  = (state == ARMED) && (cnt_in == match_val);
    raise      = seq_err || match_hit || wrap_raise;
    code_new   = CODE_NONE;
    if (seq_err)         code_new = CODE_SEQ;
    else if (match_hit)  code_new = CODE_MATCH;
    else if (wrap_raise) code_new = CODE_WRAP;
    xfer = evt_valid && evt_ready;
    load = raise && (!evt_valid || evt_ready);
    drop = raise && evt_valid && !evt_ready;
  end

  // Sample stage: the ripple counter has settled by the posedge following its negedge update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      wrap     <= 1'b0;
      first_p0 <= 1'b0;
    end else begin
      cnt_q    <= cnt_in;
      wrap     <= wrap_hit;
      first_p0 <= 1'b1;
    end
  end

  // Event register stage: a raise while stalled is lost and recorded in the sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_code  <= CODE_NONE;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= code_new;
        evt_count <= cnt_in;
      end else if (xfer) begin
        evt_valid <= 1'b0;
        evt_code  <= CODE_NONE;
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // A match that is dropped or outranked by a sequence error still ends the armed window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        ARMED: begin
          if (match_hit) begin
            state <= (load && !seq_err) ? MATCHED : IDLE;
            armed <= 1'b0;
          end
        end
        MATCHED: begin
          if (xfer && (evt_code == CODE_MATCH)) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: the bench plays the ripple counter on negedge
// and checks outputs one time unit after each posedge.
module tb_ripple_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] cnt_in;
  logic       arm;
  logic [3:0] match_val;
  logic [3:0] cnt_q;
  logic       wrap;
  logic       armed;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_code;
  logic [3:0] evt_count;
  logic       overflow;
  logic       clr_ovf;

  int total = 0;
  int bad   = 0;

  ripple_count_monitor #(.WIDTH(4), .WRAP_EVT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .arm       (arm),
    .match_val (match_val),
    .cnt_q     (cnt_q),
    .wrap      (wrap),
    .armed     (armed),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counter value changes on negedge, DUT samples on the following posedge.
  task automatic cyc(input logic [3:0] c);
    @(negedge clk);
    cnt_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_q"},     32'(cnt_q),     0);
    chk({tag, "_wrap"},      32'(wrap),      0);
    chk({tag, "_armed"},     32'(armed),     0);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 0);
    chk({tag, "_evt_code"},  32'(evt_code),  0);
    chk({tag, "_evt_count"}, 32'(evt_count), 0);
    chk({tag, "_overflow"},  32'(overflow),  0);
  endtask

  initial begin
    logic [3:0] c;
    reset     = 1'b1;
    cnt_in    = 4'd0;
    arm       = 1'b0;
    match_val = 4'd0;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;
    #3;
    chk_all_zero("rst");

    // First sample after reset: cnt_q=0 and cnt_in=0 would be a step error if not suppressed.
    @(negedge clk);
    reset  = 1'b0;
    cnt_in = 4'd0;
    @(posedge clk);
    #1;
    chk("first_cnt_q", 32'(cnt_q), 0);
    chk("first_valid", 32'(evt_valid), 0);

    // Free-running counter through two wraps, consumer always ready.
    for (int k = 1; k <= 32; k++) begin
      c = 4'(k);
      cyc(c);
      chk("run_cnt_q", 32'(cnt_q), 32'(c));
      chk("run_wrap",  32'(wrap), (c == 4'd0) ? 1 : 0);
      chk("run_valid", 32'(evt_valid), (c == 4'd0) ? 1 : 0);
      if (c == 4'd0) begin
        chk("run_wrap_code",  32'(evt_code), 2);
        chk("run_wrap_count", 32'(evt_count), 0);
      end
    end

    // Match on 9, armed while the counter shows 3.
    cyc(4'd1);
    chk("drain_valid", 32'(evt_valid), 0);
    cyc(4'd2);
    arm = 1'b1;
    match_val = 4'd9;
    cyc(4'd3);
    arm = 1'b0;
    chk("arm_armed", 32'(armed), 1);
    for (int v = 4; v <= 8; v++) begin
      cyc(4'(v));
      chk("arm_hold", 32'(armed), 1);
      chk("arm_novalid", 32'(evt_valid), 0);
    end
    cyc(4'd9);
    chk("match_valid", 32'(evt_valid), 1);
    chk("match_code",  32'(evt_code), 1);
    chk("match_count", 32'(evt_count), 9);
    chk("match_armed", 32'(armed), 0);
    cyc(4'd10);
    chk("match_acc_valid", 32'(evt_valid), 0);
    chk("match_acc_code",  32'(evt_code), 0);
    chk("match_acc_armed", 32'(armed), 0);

    // Jump 5 -> 8 while armed for 8: sequence error outranks the match.
    for (int v = 11; v <= 15; v++) cyc(4'(v));
    cyc(4'd0);
    chk("wrap2_code", 32'(evt_code), 2);
    cyc(4'd1);
    cyc(4'd2);
    arm = 1'b1;
    match_val = 4'd8;
    cyc(4'd3);
    arm = 1'b0;
    chk("seq_armed", 32'(armed), 1);
    cyc(4'd4);
    cyc(4'd5);
    chk("seq_pre_valid", 32'(evt_valid), 0);
    cyc(4'd8);
    chk("seq_valid", 32'(evt_valid), 1);
    chk("seq_code",  32'(evt_code), 3);
    chk("seq_count", 32'(evt_count), 8);
    chk("seq_ovf",   32'(overflow), 0);
    cyc(4'd9);
    chk("seq_acc_valid", 32'(evt_valid), 0);

    // Consumer stalled across two wraps.
    evt_ready = 1'b0;
    for (int v = 10; v <= 15; v++) cyc(4'(v));
    cyc(4'd0);
    chk("stall_valid", 32'(evt_valid), 1);
    chk("stall_code",  32'(evt_code), 2);
    chk("stall_ovf",   32'(overflow), 0);
    for (int v = 1; v <= 15; v++) begin
      cyc(4'(v));
      chk("stall_hold_code",  32'(evt_code), 2);
      chk("stall_hold_count", 32'(evt_count), 0);
    end
    cyc(4'd0);
    chk("drop_ovf",   32'(overflow), 1);
    chk("drop_valid", 32'(evt_valid), 1);
    chk("drop_code",  32'(evt_code), 2);
    clr_ovf = 1'b1;
    cyc(4'd1);
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_code", 32'(evt_code), 2);
    clr_ovf = 1'b1;
    cyc(4'd5);
    clr_ovf = 1'b0;
    chk("clr_vs_drop_ovf",  32'(overflow), 1);
    chk("clr_vs_drop_code", 32'(evt_code), 2);

    // Transfer and new raise in the same edge: no bubble.
    evt_ready = 1'b1;
    cyc(4'd9);
    chk("b2b_valid", 32'(evt_valid), 1);
    chk("b2b_code",  32'(evt_code), 3);
    chk("b2b_count", 32'(evt_count), 9);
    chk("b2b_ovf",   32'(overflow), 1);
    clr_ovf = 1'b1;
    cyc(4'd10);
    clr_ovf = 1'b0;
    chk("b2b_drain_valid", 32'(evt_valid), 0);
    chk("b2b_drain_code",  32'(evt_code), 0);
    chk("b2b_drain_ovf",   32'(overflow), 0);

    // Asynchronous reset while ARMED with an event pending.
    evt_ready = 1'b0;
    arm = 1'b1;
    match_val = 4'd3;
    cyc(4'd11);
    arm = 1'b0;
    chk("pre_rst_armed", 32'(armed), 1);
    cyc(4'd14);
    chk("pre_rst_valid", 32'(evt_valid), 1);
    chk("pre_rst_armed2", 32'(armed), 1);
    chk("pre_rst_cnt_q", 32'(cnt_q), 14);
    #2;
    reset  = 1'b1;
    cnt_in = 4'd0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    reset  = 1'b0;
    cnt_in = 4'd0;
    @(posedge clk);
    #1;
    chk("post_rst0_valid", 32'(evt_valid), 0);
    chk("post_rst0_cnt_q", 32'(cnt_q), 0);
    cyc(4'd1);
    chk("post_rst1_valid", 32'(evt_valid), 0);
    chk("post_rst1_code",  32'(evt_code), 0);
    chk("post_rst1_cnt_q", 32'(cnt_q), 1);
    cyc(4'd2);
    chk("post_rst2_valid", 32'(evt_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
